// File: rtl/sisc_pkg.sv
// Shared SISC definitions: arbiter state/owner encodings and default bus widths.
package sisc_pkg;

   localparam int unsigned SISC_ADDR_W = 16;
   localparam int unsigned SISC_DATA_W = 32;
   localparam int unsigned LAT_W       = 4;
   localparam int unsigned STARVE_W    = 4;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/mem_arb_if.sv
// Request/grant/valid bundle between fetch, data path, arbiter and memory array.
interface mem_arb_if #(
   parameter int unsigned ADDR_W = sisc_pkg::SISC_ADDR_W,
   parameter int unsigned DATA_W = sisc_pkg::SISC_DATA_W
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_valid;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   // Arbiter view
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   // Environment view: requesters plus memory array
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arb.sv
// Single-port memory arbiter: shares one synchronous memory between instruction
// fetch (read-only) and the data path, with one access in flight at a time.
module mem_arb
   import sisc_pkg::*;
#(
   parameter int unsigned ADDR_W     = SISC_ADDR_W,
   parameter int unsigned DATA_W     = SISC_DATA_W,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic      clk,
   input logic      rst_f,
   mem_arb_if.slave bus
);

   localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(MEM_LAT - 1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   arb_state_e          state;
   arb_owner_e          owner;
   logic [LAT_W-1:0]    lat_cnt;
   logic [STARVE_W-1:0] starve_cnt;
   logic                lat_we;
   logic                req_any_c;
   logic                pick_dm_c;

   // Data wins a tie unless fetch has already been passed over STARVE_MAX times.
   always_comb begin
      req_any_c = bus.if_req | bus.dm_req;
      pick_dm_c = bus.dm_req & (~bus.if_req | (starve_cnt != STARVE_LIM));
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state         <= ARB_IDLE;
         owner         <= OWN_IF;
         lat_cnt       <= '0;
         starve_cnt    <= '0;
         lat_we        <= 1'b0;
         bus.if_gnt    <= 1'b0;
         bus.if_valid  <= 1'b0;
         bus.if_rdata  <= {DATA_W{1'b0}};
         bus.dm_gnt    <= 1'b0;
         bus.dm_valid  <= 1'b0;
         bus.dm_rdata  <= {DATA_W{1'b0}};
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= {ADDR_W{1'b0}};
         bus.mem_wdata <= {DATA_W{1'b0}};
         bus.busy      <= 1'b0;
      end else begin
         bus.if_gnt <= 1'b0;
         bus.dm_gnt <= 1'b0;
         bus.mem_en <= 1'b0;
         bus.mem_we <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (req_any_c) begin
                  state      <= ARB_ACCESS;
                  lat_cnt    <= LAT_LAST;
                  bus.busy   <= 1'b1;
                  bus.mem_en <= 1'b1;
                  if (pick_dm_c) begin
                     owner         <= OWN_DM;
                     lat_we        <= bus.dm_we;
                     bus.dm_gnt    <= 1'b1;
                     bus.mem_we    <= bus.dm_we;
                     bus.mem_addr  <= bus.dm_addr;
                     bus.mem_wdata <= bus.dm_wdata;
                     if (bus.if_req && (starve_cnt < STARVE_LIM))
                        starve_cnt <= starve_cnt + STARVE_W'(1);
                  end else begin
                     owner         <= OWN_IF;
                     lat_we        <= 1'b0;
                     bus.if_gnt    <= 1'b1;
                     bus.mem_addr  <= bus.if_addr;
                     bus.mem_wdata <= {DATA_W{1'b0}};
                     starve_cnt    <= '0;
                  end
               end
            end
            ARB_ACCESS: begin
               // Memory data is captured at the edge closing the last access cycle.
               if (lat_cnt == '0) begin
                  state         <= ARB_RESP;
                  bus.mem_addr  <= {ADDR_W{1'b0}};
                  bus.mem_wdata <= {DATA_W{1'b0}};
                  if (owner == OWN_DM) begin
                     bus.dm_valid <= 1'b1;
                     bus.dm_rdata <= lat_we ? {DATA_W{1'b0}} : bus.mem_rdata;
                  end else begin
                     bus.if_valid <= 1'b1;
                     bus.if_rdata <= bus.mem_rdata;
                  end
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            ARB_RESP: begin
               state        <= ARB_IDLE;
               bus.busy     <= 1'b0;
               bus.if_valid <= 1'b0;
               bus.if_rdata <= {DATA_W{1'b0}};
               bus.dm_valid <= 1'b0;
               bus.dm_rdata <= {DATA_W{1'b0}};
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: a MEM_LAT=2 and a MEM_LAT=1 instance driven by directed and
// random requests, checked cycle by cycle against a transaction-level model.
module tb_mem_arb;
   import sisc_pkg::*;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int L0   = 2;
   localparam int L1   = 1;
   localparam int SMAX = 4;

   typedef struct packed {
      logic          if_gnt;
      logic          if_valid;
      logic [DW-1:0] if_rdata;
      logic          dm_gnt;
      logic          dm_valid;
      logic [DW-1:0] dm_rdata;
      logic          mem_en;
      logic          mem_we;
      logic [AW-1:0] mem_addr;
      logic [DW-1:0] mem_wdata;
      logic          busy;
   } obs_t;

   logic clk   = 1'b0;
   logic rst_f = 1'b0;
   always #5 clk = ~clk;

   logic          sel  = 1'b0;
   logic          r_if = 1'b0;
   logic          r_dm = 1'b0;
   logic          r_we = 1'b0;
   logic [AW-1:0] r_ia = '0;
   logic [AW-1:0] r_da = '0;
   logic [DW-1:0] r_wd = '0;

   int total = 0;
   int bad   = 0;
   int starve [2] = '{0, 0};
   bit exp_ord [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   logic [DW-1:0] mem     [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   obs_t o0, o1;

   mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
   mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();

   mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L0), .STARVE_MAX(SMAX)) u0 (
      .clk(clk), .rst_f(rst_f), .bus(b0.slave));
   mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L1), .STARVE_MAX(SMAX)) u1 (
      .clk(clk), .rst_f(rst_f), .bus(b1.slave));

   assign b0.if_req   = r_if & ~sel;
   assign b0.dm_req   = r_dm & ~sel;
   assign b1.if_req   = r_if & sel;
   assign b1.dm_req   = r_dm & sel;
   assign b0.if_addr  = r_ia;
   assign b1.if_addr  = r_ia;
   assign b0.dm_addr  = r_da;
   assign b1.dm_addr  = r_da;
   assign b0.dm_we    = r_we;
   assign b1.dm_we    = r_we;
   assign b0.dm_wdata = r_wd;
   assign b1.dm_wdata = r_wd;

   assign o0 = {b0.if_gnt, b0.if_valid, b0.if_rdata, b0.dm_gnt, b0.dm_valid, b0.dm_rdata,
                b0.mem_en, b0.mem_we, b0.mem_addr, b0.mem_wdata, b0.busy};
   assign o1 = {b1.if_gnt, b1.if_valid, b1.if_rdata, b1.dm_gnt, b1.dm_valid, b1.dm_rdata,
                b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.busy};

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return (a == 16'h0010) ? 32'h8A00_0001 : ({~a, a} ^ 32'h1357_2468);
   endfunction

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      return mem.exists(a) ? mem[a] : dflt(a);
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   // Memory array: writes on the rising edge, read data settles mid-cycle.
   always @(posedge clk) begin
      if (b0.mem_en && b0.mem_we) mem[b0.mem_addr] = b0.mem_wdata;
      if (b1.mem_en && b1.mem_we) mem[b1.mem_addr] = b1.mem_wdata;
   end
   always @(negedge clk) begin
      b0.mem_rdata <= mem_rd(b0.mem_addr);
      b1.mem_rdata <= mem_rd(b1.mem_addr);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=still running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One arbitration + access; entered at the falling edge of an IDLE cycle, returns at
   // the falling edge of the IDLE cycle that follows RESP.
   task automatic access(input bit hold_w, output bit got_dm, output time t_gnt);
      int            s;
      int            lat;
      bit            dm_w;
      bit            ewe;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      logic [DW-1:0] erd;
      obs_t          o;
      string         p;
      s      = int'(sel);
      lat    = sel ? L1 : L0;
      got_dm = 1'b0;
      t_gnt  = 0;
      dm_w   = r_dm && (!r_if || starve[s] != SMAX);
      if (dm_w) begin
         ea = r_da; ewe = r_we; ewd = r_wd;
         if (r_if && starve[s] < SMAX) starve[s]++;
      end else begin
         ea = r_ia; ewe = 1'b0; ewd = '0;
         starve[s] = 0;
      end
      erd = ewe ? '0 : ref_rd(ea);
      if (ewe) ref_mem[ea] = ewd;
      @(posedge clk);
      for (int c = 1; c <= lat + 2; c++) begin
         @(negedge clk);
         o = sel ? o1 : o0;
         p = $sformatf("u%0d c%0d", s, c);
         if (c == 1) begin
            got_dm = o.dm_gnt;
            t_gnt  = $time;
            chk({p, " gnt"}, 128'({o.if_gnt, o.dm_gnt}), 128'({!dm_w, dm_w}));
            chk({p, " mem_en/we"}, 128'({o.mem_en, o.mem_we}), 128'({1'b1, ewe}));
            chk({p, " mem_addr"}, 128'(o.mem_addr), 128'(ea));
            chk({p, " mem_wdata"}, 128'(o.mem_wdata), 128'(ewd));
            chk({p, " busy/valid"}, 128'({o.busy, o.if_valid, o.dm_valid}), 128'(3'b100));
            if (!hold_w) begin
               if (dm_w) r_dm = 1'b0;
               else      r_if = 1'b0;
            end
         end else if (c <= lat) begin
            chk({p, " gnt/en/we"}, 128'({o.if_gnt, o.dm_gnt, o.mem_en, o.mem_we}), 128'(0));
            chk({p, " mem_addr"}, 128'(o.mem_addr), 128'(ea));
            chk({p, " mem_wdata"}, 128'(o.mem_wdata), 128'(ewd));
            chk({p, " busy/valid"}, 128'({o.busy, o.if_valid, o.dm_valid}), 128'(3'b100));
         end else if (c == lat + 1) begin
            chk({p, " valid"}, 128'({o.if_valid, o.dm_valid}), 128'({!dm_w, dm_w}));
            chk({p, " if_rdata"}, 128'(o.if_rdata), 128'(dm_w ? '0 : erd));
            chk({p, " dm_rdata"}, 128'(o.dm_rdata), 128'(dm_w ? erd : '0));
            chk({p, " resp mem"}, 128'({o.mem_en, o.mem_we, o.mem_addr, o.mem_wdata}), 128'(0));
            chk({p, " resp busy/gnt"}, 128'({o.busy, o.if_gnt, o.dm_gnt}), 128'(3'b100));
         end else begin
            chk({p, " idle"}, 128'(o), 128'(0));
         end
      end
   endtask

   task automatic rand_reqs();
      if (!r_if && $urandom_range(0, 1) == 1) begin
         r_if = 1'b1;
         r_ia = AW'($urandom_range(0, 15));
      end
      if (!r_dm && $urandom_range(0, 1) == 1) begin
         r_dm = 1'b1;
         r_we = 1'($urandom_range(0, 1));
         r_da = AW'($urandom_range(0, 15));
         r_wd = $urandom;
      end
      if (!r_if && !r_dm) begin
         r_if = 1'b1;
         r_ia = AW'($urandom_range(0, 15));
      end
   endtask

   initial begin
      bit  g;
      time t1;
      time t2;

      // Reset values
      repeat (2) @(negedge clk);
      chk("reset u0", 128'(o0), 128'(0));
      chk("reset u1", 128'(o1), 128'(0));
      rst_f = 1'b1;

      // Fetch only
      r_if = 1'b1; r_ia = 16'h0010;
      access(1'b0, g, t1);

      // Store then load back
      r_dm = 1'b1; r_we = 1'b1; r_da = 16'h0100; r_wd = 32'hDEAD_BEEF;
      access(1'b0, g, t1);
      r_dm = 1'b1; r_we = 1'b0; r_da = 16'h0100;
      access(1'b0, g, t1);

      // Both held: starvation guard lets fetch through on the fifth grant
      r_if = 1'b1; r_ia = 16'h0020;
      r_dm = 1'b1; r_we = 1'b0; r_da = 16'h0021;
      for (int i = 0; i < 6; i++) begin
         access(1'b1, g, t1);
         chk($sformatf("order %0d", i), 128'(g), 128'(exp_ord[i]));
         if (i == 4) chk("starve clr", 128'(u0.starve_cnt), 128'(0));
      end
      r_if = 1'b0; r_dm = 1'b0;

      // Held fetch request is regranted after MEM_LAT+2 cycles
      r_if = 1'b1; r_ia = 16'h0030;
      access(1'b1, g, t1);
      access(1'b0, g, t2);
      chk("held gap", 128'((t2 - t1) / 10), 128'(L0 + 2));

      // Reset in the second access cycle of a load
      r_dm = 1'b1; r_we = 1'b0; r_da = 16'h0005;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid gnt", 128'(o0.dm_gnt), 128'(1));
      r_dm = 1'b0;
      @(posedge clk);
      #2 rst_f = 1'b0;
      #1;
      chk("rst_mid en/busy/gnt", 128'({o0.mem_en, o0.busy, o0.if_gnt, o0.dm_gnt}), 128'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_mid no valid", 128'(o0.dm_valid), 128'(0));
      end
      rst_f = 1'b1;
      starve[0] = 0; starve[1] = 0;
      r_if = 1'b1; r_ia = 16'h0003;
      access(1'b0, g, t1);

      // Random traffic, MEM_LAT = 2
      for (int i = 0; i < 40; i++) begin
         rand_reqs();
         access(1'b0, g, t1);
      end
      r_if = 1'b0; r_dm = 1'b0;

      // MEM_LAT = 1: alternating loads and fetches, then random traffic
      sel = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            r_dm = 1'b1; r_we = 1'b0; r_da = AW'($urandom_range(0, 15));
         end else begin
            r_if = 1'b1; r_ia = AW'($urandom_range(0, 15));
         end
         access(1'b0, g, t1);
      end
      for (int i = 0; i < 40; i++) begin
         rand_reqs();
         access(1'b0, g, t1);
      end
      r_if = 1'b0; r_dm = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
